dmem_arbiter: RTL

Sequences and shares the single-port Data_Memory between two requesters. Master 0 is the CPU MEM stage; master 1 is a debug/DMA loader.
- Each access runs as a multi-cycle transaction with a configurable access time.
- The block holds address, data and strobes stable to the memory for the whole access.
- It returns read data with a one-cycle ack pulse.
- It produces a stall for the CPU pipeline.

---
 rtl/dmem_arb_pkg.sv | 15 +
 rtl/dmem_arb_grant.sv | 34 +++
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// State encoding, master indices and the access-time counter width.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic M_CPU = 1'b0;
   localparam logic M_DBG = 1'b1;
   localparam int   CNT_W = 4;

endpackage

// File: rtl/dmem_arb_grant.sv
// Combinational winner selection between the CPU and the debug/DMA master.
// DMEM_ARB_RR_EN selects round-robin; otherwise fixed priority m0 > m1.
module dmem_arb_grant
   import dmem_arb_pkg::*;
(
   input  logic m0_req,
   input  logic m1_req,
   input  logic last_grant,
   output logic any_req,
   output logic win
);

`ifndef DMEM_ARB_RR_EN
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

   always_comb begin
      any_req = m0_req | m1_req;
      win     = M_CPU;
`ifdef DMEM_ARB_RR_EN
      if (m0_req && m1_req) begin
         win = ~last_grant;
      end else if (m1_req) begin
         win = M_DBG;
      end
`else
      if (!m0_req && m1_req) begin
         win = M_DBG;
      end
`endif
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master sequencer for the single-port Data_Memory with fixed access time.
// Build option DMEM_ARB_RR_EN: round-robin instead of fixed m0-first priority.
//
// state  | meaning
// IDLE   | arbitrate, latch winner's command, load access counter
// ACCESS | strobes held for MEM_LATENCY cycles, read data captured on the last
// RESP   | one-cycle ack to the granted master, strobes low
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int MEM_LATENCY = 2,
   parameter int DATA_W      = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic [DATA_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic              m0_ack_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   input  logic              m1_req_i,
   input  logic              m1_we_i,
   input  logic [DATA_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m1_ack_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic [DATA_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic              mem_wr_o,
   output logic              mem_rd_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              cpu_stall_o
);

`ifndef SYNTHESIS
   if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
      $error("dmem_arbiter: MEM_LATENCY=%0d outside 1..15", MEM_LATENCY);
   end
`endif

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             grant;
   logic             lat_we;
   logic             last_grant;
   logic             any_req;
   logic             win;

`ifndef DMEM_ARB_RR_EN
   assign last_grant = 1'b1;
`endif

   dmem_arb_grant u_grant (
      .m0_req     (m0_req_i),
      .m1_req     (m1_req_i),
      .last_grant (last_grant),
      .any_req    (any_req),
      .win        (win)
   );

   assign cpu_stall_o = m0_req_i & ~m0_ack_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         cnt         <= '0;
         grant       <= M_CPU;
         lat_we      <= 1'b0;
`ifdef DMEM_ARB_RR_EN
         last_grant  <= M_DBG;
`endif
         m0_ack_o    <= 1'b0;
         m1_ack_o    <= 1'b0;
         m0_rdata_o  <= '0;
         m1_rdata_o  <= '0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         mem_wr_o    <= 1'b0;
         mem_rd_o    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               m0_ack_o <= 1'b0;
               m1_ack_o <= 1'b0;
               if (any_req) begin
                  grant <= win;
`ifdef DMEM_ARB_RR_EN
                  last_grant <= win;
`endif
                  if (win == M_DBG) begin
                     lat_we      <= m1_we_i;
                     mem_addr_o  <= m1_addr_i;
                     mem_wdata_o <= m1_wdata_i;
                     mem_wr_o    <= m1_we_i;
                     mem_rd_o    <= ~m1_we_i;
                  end else begin
                     lat_we      <= m0_we_i;
                     mem_addr_o  <= m0_addr_i;
                     mem_wdata_o <= m0_wdata_i;
                     mem_wr_o    <= m0_we_i;
                     mem_rd_o    <= ~m0_we_i;
                  end
                  cnt   <= CNT_LOAD;
                  state <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt == '0) begin
                  mem_wr_o <= 1'b0;
                  mem_rd_o <= 1'b0;
                  // read data sampled in the last strobe cycle; writes leave rdata alone
                  if (grant == M_DBG) begin
                     m1_ack_o <= 1'b1;
                     if (!lat_we) m1_rdata_o <= mem_rdata_i;
                  end else begin
                     m0_ack_o <= 1'b1;
                     if (!lat_we) m0_rdata_o <= mem_rdata_i;
                  end
                  state <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               m0_ack_o <= 1'b0;
               m1_ack_o <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               m0_ack_o <= 1'b0;
               m1_ack_o <= 1'b0;
               mem_wr_o <= 1'b0;
               mem_rd_o <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
